// File: rtl/prga_fifo_param.sv
// prga_fifo_param: parametrised single-clock FIFO with standard (registered) or lookahead read port,
// occupancy count and almost-full flag. Define PRGA_FIFO_ERROR_CHECK_EN for sticky err_ovf/err_udf.
`timescale 1ns/1ps
module prga_fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 3,
    parameter int LOOKAHEAD  = 0,
    parameter int AF_THRESH  = (2 ** DEPTH_LOG2) - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
`ifdef PRGA_FIFO_ERROR_CHECK_EN
    ,
    output logic                  err_ovf,
    output logic                  err_udf
`endif
);

    localparam int CW = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] ZERO_C  = CW'(0);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  wr_acc_s, rd_acc_s;
    logic [DEPTH_LOG2-1:0] head_idx_s;

    // Accept decisions use only registered flags, so no wr/rd -> flag combinational path exists.
    always_comb begin
        wr_acc_s = wr && !full_q;
        rd_acc_s = rd && !empty_q;
    end

    // Pointer, occupancy and flag next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + ONE_C;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + ONE_C;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == ZERO_C);
        af_d    = (count_d >= AF_C);
    end

    // Read data next-state. Lookahead presents the post-edge head; a head being written on
    // this same edge (write into empty, or the last entry popped while writing) bypasses from din.
    always_comb begin
        head_idx_s = rd_ptr_d[DEPTH_LOG2-1:0];
        dout_d     = dout_q;
        if (LOOKAHEAD != 0) begin
            if (count_d == ZERO_C) begin
                dout_d = dout_q;
            end else if (wr_acc_s && (wr_ptr_q[DEPTH_LOG2-1:0] == head_idx_s)) begin
                dout_d = din;
            end else begin
                dout_d = mem_q[head_idx_s];
            end
        end else begin
            if (rd_acc_s) begin
                dout_d = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
            end else begin
                dout_d = dout_q;
            end
        end
    end

    // Storage array; contents are not reset since only written entries are ever read.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= ZERO_C;
            rd_ptr_q <= ZERO_C;
            count_q  <= ZERO_C;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            dout_q   <= {DATA_WIDTH{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            dout_q   <= dout_d;
        end
    end

    assign full        = full_q;
    assign almost_full = af_q;
    assign empty       = empty_q;
    assign count       = count_q;
    assign dout        = dout_q;

`ifdef PRGA_FIFO_ERROR_CHECK_EN
    logic err_ovf_q, err_ovf_d;
    logic err_udf_q, err_udf_d;

    // Sticky error next-state: any illegal request sets, only reset clears.
    always_comb begin
        err_ovf_d = err_ovf_q | (wr & full_q);
        err_udf_d = err_udf_q | (rd & empty_q);
    end

    // Sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

`ifndef SYNTHESIS
    // First-occurrence simulation messages.
    always @(posedge clk) begin
        if (rst_n && wr && full_q && !err_ovf_q) begin
            $display("prga_fifo_param %m: overflow (write while full) at time %0t", $time);
        end
        if (rst_n && rd && empty_q && !err_udf_q) begin
            $display("prga_fifo_param %m: underflow (read while empty) at time %0t", $time);
        end
    end
`endif

    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;
`endif

endmodule

// File: tb/tb_prga_fifo_param.sv
// Randomised scoreboard bench for prga_fifo_param: one standard and one lookahead instance
// share stimulus and are checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_prga_fifo_param;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int DEPTH = 8;
    localparam int AF = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic [DW-1:0] din = '0;

    logic          full0, af0, empty0, full1, af1, empty1;
    logic [DW-1:0] dout0, dout1;
    logic [AW:0]   count0, count1;
`ifdef PRGA_FIFO_ERROR_CHECK_EN
    logic          eo0, eu0, eo1, eu1;
`endif

    always #10 clk = ~clk;

    prga_fifo_param #(.DATA_WIDTH(DW), .DEPTH_LOG2(AW), .LOOKAHEAD(0), .AF_THRESH(AF)) u0 (
        .clk(clk), .rst_n(rst_n), .wr(wr), .din(din), .full(full0), .almost_full(af0),
        .rd(rd), .dout(dout0), .empty(empty0), .count(count0)
`ifdef PRGA_FIFO_ERROR_CHECK_EN
        , .err_ovf(eo0), .err_udf(eu0)
`endif
    );

    prga_fifo_param #(.DATA_WIDTH(DW), .DEPTH_LOG2(AW), .LOOKAHEAD(1), .AF_THRESH(AF)) u1 (
        .clk(clk), .rst_n(rst_n), .wr(wr), .din(din), .full(full1), .almost_full(af1),
        .rd(rd), .dout(dout1), .empty(empty1), .count(count1)
`ifdef PRGA_FIFO_ERROR_CHECK_EN
        , .err_ovf(eo1), .err_udf(eu1)
`endif
    );

    typedef struct {
        int            cnt;
        bit            emp;
        bit            ful;
        bit            af;
        logic [DW-1:0] head;
    } exp_t;

    exp_t          state_q[$];
    logic [DW-1:0] rdexp_q[$];
    logic [DW-1:0] model[$];
    logic [DW-1:0] last0 = '0;
    int            n_tests = 0;
    int            n_fail = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Issue one cycle of stimulus and push the expected post-edge state.
    task automatic step(input bit w, input bit r, input logic [DW-1:0] d);
        exp_t e;
        bit   wa, ra;
        @(negedge clk);
        wr = w; rd = r; din = d;
        wa = w && (model.size() < DEPTH);
        ra = r && (model.size() > 0);
        if (ra) rdexp_q.push_back(model.pop_front());
        if (wa) model.push_back(d);
        e.cnt  = model.size();
        e.emp  = (e.cnt == 0);
        e.ful  = (e.cnt == DEPTH);
        e.af   = (e.cnt >= AF);
        e.head = e.emp ? '0 : model[0];
        state_q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && model.size() > 0; i++) step(1'b0, 1'($urandom_range(0, 1)), '0);
        step(1'b0, 1'b0, '0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_flags0", {count0, full0, empty0, af0}, {4'd0, 1'b0, 1'b1, 1'b0});
        chk("async_rst_flags1", {count1, full1, empty1, af1}, {4'd0, 1'b0, 1'b1, 1'b0});
        chk("async_rst_dout0", dout0, 64'd0);
        chk("async_rst_dout1", dout1, 64'd0);
        wr = 1'b0; rd = 1'b0;
        model.delete(); rdexp_q.delete(); state_q.delete(); last0 = '0;
        #2;
        rst_n = 1'b1;
    endtask

    exp_t me;
    bit   mon_took;
    bit   mon_chk;

    // Monitor: compares DUT outputs after each edge against the scoreboard.
    always @(posedge clk) begin
        mon_took = rd && !empty0 && rst_n;
        #1;
        mon_chk = 1'b0;
        if (state_q.size() > 0) begin
            me = state_q.pop_front();
            mon_chk = 1'b1;
            chk("flags0", {count0, full0, empty0, af0}, {4'(me.cnt), me.ful, me.emp, me.af});
            chk("flags1", {count1, full1, empty1, af1}, {4'(me.cnt), me.ful, me.emp, me.af});
            if (!me.emp) chk("dout_lookahead", dout1, me.head);
        end
        if (mon_took) begin
            if (rdexp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL read_no_expect: dout0=%0h with no expected read at %0t", dout0, $time);
            end else begin
                last0 = rdexp_q.pop_front();
            end
        end
        if (mon_chk) chk("dout_std", dout0, last0);
    end

    logic [DW-1:0] v;
    int            written;
    logic [DW-1:0] la_data [4];

    initial begin
        la_data[0] = 32'h5A; la_data[1] = 32'hF6; la_data[2] = 32'h09; la_data[3] = 32'hC4;
        repeat (2) @(negedge clk);
        chk("reset_flags0", {count0, full0, empty0, af0}, {4'd0, 1'b0, 1'b1, 1'b0});
        chk("reset_flags1", {count1, full1, empty1, af1}, {4'd0, 1'b0, 1'b1, 1'b0});
        chk("reset_dout", {dout0, dout1}, 64'd0);
        chk("reset_no_x", 64'($isunknown({full0, af0, empty0, dout0, count0, full1, af1, empty1, dout1, count1})), 64'd0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, '0);

        // Lookahead directed sequence with random read gaps.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, la_data[i]);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, '0);
            step(1'b0, 1'b1, '0);
        end
        step(1'b0, 1'b0, '0);

        // Fill, dropped write while full, then rd+wr while full.
        for (int i = 0; i < 8; i++) begin
            v = $urandom;
            if (v == 32'hE2) v = 32'h1;
            step(1'b1, 1'b0, v);
        end
        step(1'b1, 1'b0, 32'hE2);
        step(1'b1, 1'b1, 32'h7A);
        drain();

        // Half-full streaming with simultaneous rd+wr across pointer wrap.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, $urandom);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, $urandom);
        drain();

        // Random 1024-word stream.
        written = 0;
        for (int c = 0; c < 8000 && written < 1024; c++) begin
            bit w, r;
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (w && model.size() < DEPTH) written++;
            step(w, r, $urandom);
        end
        chk("stream_len", 64'(written), 64'd1024);
        drain();

        // Mid-burst asynchronous reset with five entries held.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, $urandom);
        reset_pulse();
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 32'h33);
        drain();

`ifdef PRGA_FIFO_ERROR_CHECK_EN
        step(1'b0, 1'b1, '0);
        repeat (3) step(1'b0, 1'b0, '0);
        @(negedge clk);
        chk("err_udf", {eu0, eu1}, 64'd3);
        chk("err_ovf_clear", {eo0, eo1}, 64'd0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(state_q.size() + rdexp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
